// File: rtl/sram_bank_array_pm.sv
// Single-bank SRAM macro model plus a multi-bank array with ON/RET/WAKE power FSMs per bank.
// Grant is combinational, read data arrives one cycle after a granted read, and a non-ON bank stalls the requester.
module sram_wrapper #(
  parameter  int Words = 2048,
  localparam int AW    = $clog2(Words)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    be_i,
  input  logic          set_retentive_ni,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [Words];
  logic [31:0] rdata_q;
  logic [31:0] bit_en;
  logic        access;

  assign bit_en = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
  assign access = req_i & set_retentive_ni;

  // The array has no reset so contents survive both reset and retention.
  always_ff @(posedge clk_i) begin
    if (access && we_i) begin
      mem_q[addr_i] <= (mem_q[addr_i] & ~bit_en) | (wdata_i & bit_en);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (access && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// Banked SRAM: each bank drops to retention on request or idle timeout and wakes on access.
// gnt_o same cycle for an ON bank, WakeupCycles+1 cycles later for a retained bank; rvalid_o one cycle after a read grant.
module sram_bank_array_pm #(
  parameter  int NumBanks     = 4,
  parameter  int WordsPerBank = 2048,
  parameter  int Interleaved  = 0,
  parameter  int WakeupCycles = 4,
  parameter  int IdleCycles   = 64,
  localparam int BankBits     = $clog2(NumBanks),
  localparam int WordBits     = $clog2(WordsPerBank),
  localparam int AddrWidth    = BankBits + WordBits
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [31:0]          wdata_i,
  input  logic [3:0]           be_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [31:0]          rdata_o,
  input  logic [NumBanks-1:0]  ret_req_i,
  output logic [NumBanks-1:0]  bank_on_o
);
  localparam int IdleW = (IdleCycles > 1) ? $clog2(IdleCycles) : 1;
  localparam int WakeW = (WakeupCycles > 1) ? $clog2(WakeupCycles) : 1;
  localparam logic [IdleW-1:0] IdleMax = IdleW'((IdleCycles > 0) ? IdleCycles - 1 : 0);
  localparam logic [WakeW-1:0] WakeMax = WakeW'(WakeupCycles - 1);
  localparam bit IdleEn = (IdleCycles != 0);

  typedef enum logic [1:0] {StOn, StRet, StWake} pm_state_e;

  logic [BankBits-1:0] bank_sel;
  logic [WordBits-1:0] word_sel;
  logic [NumBanks-1:0] bank_on_vec;
  logic [31:0]         bank_rdata [NumBanks];
  logic                rvalid_q;
  logic [BankBits-1:0] rbank_q;
  logic [31:0]         rdata_q;

  if (Interleaved != 0) begin : g_dec_il
    assign bank_sel = addr_i[BankBits-1:0];
    assign word_sel = addr_i[AddrWidth-1:BankBits];
  end else begin : g_dec_lin
    assign bank_sel = addr_i[AddrWidth-1 -: BankBits];
    assign word_sel = addr_i[WordBits-1:0];
  end

  assign gnt_o = req_i & bank_on_vec[bank_sel] & ~ret_req_i[bank_sel];

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    pm_state_e        state_q, state_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic [WakeW-1:0] wake_q, wake_d;
    logic             on_q;
    logic             sel;
    logic             bank_gnt;

    assign sel      = (bank_sel == BankBits'(b));
    assign bank_gnt = gnt_o & sel;

    always_comb begin
      state_d = state_q;
      idle_d  = idle_q;
      wake_d  = wake_q;
      unique case (state_q)
        StOn: begin
          if (bank_gnt) begin
            idle_d = '0;
          end else if (idle_q != IdleMax) begin
            idle_d = idle_q + 1'b1;
          end
          if (ret_req_i[b] || (IdleEn && idle_q == IdleMax && !bank_gnt)) begin
            state_d = StRet;
            idle_d  = '0;
          end
        end
        StRet: begin
          if (req_i && sel && !ret_req_i[b]) begin
            state_d = StWake;
            wake_d  = WakeMax;
          end
        end
        StWake: begin
          // A new retention request aborts the wake-up.
          if (ret_req_i[b]) begin
            state_d = StRet;
            wake_d  = '0;
          end else if (wake_q == '0) begin
            state_d = StOn;
            idle_d  = '0;
          end else begin
            wake_d = wake_q - 1'b1;
          end
        end
        default: state_d = StOn;
      endcase
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= StOn;
        idle_q  <= '0;
        wake_q  <= '0;
        on_q    <= 1'b1;
      end else begin
        state_q <= state_d;
        idle_q  <= idle_d;
        wake_q  <= wake_d;
        on_q    <= (state_d == StOn);
      end
    end

    assign bank_on_vec[b] = on_q;

    sram_wrapper #(
      .Words (WordsPerBank)
    ) u_sram (
      .clk_i            (clk_i),
      .rst_ni           (~rst_i),
      .req_i            (bank_gnt),
      .we_i             (we_i),
      .addr_i           (word_sel),
      .wdata_i          (wdata_i),
      .be_i             (be_i),
      .set_retentive_ni (state_q != StRet),
      .rdata_o          (bank_rdata[b])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rbank_q  <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= gnt_o & ~we_i;
      if (gnt_o && !we_i) begin
        rbank_q <= bank_sel;
      end
      if (rvalid_q) begin
        rdata_q <= bank_rdata[rbank_q];
      end
    end
  end

  // Outside a response cycle the last returned word is held.
  assign rdata_o   = rvalid_q ? bank_rdata[rbank_q] : rdata_q;
  assign rvalid_o  = rvalid_q;
  assign bank_on_o = bank_on_vec;
endmodule

// File: tb/tb_sram_bank_array_pm.sv
// Scoreboard bench for sram_bank_array_pm (4 interleaved banks, 4-cycle wake, 64-cycle idle timeout).
module tb_sram_bank_array_pm;
  localparam int NB = 4;
  localparam int AW = 13;

  logic          clk_i = 1'b0;
  logic          rst_i, req_i, we_i;
  logic [AW-1:0] addr_i;
  logic [31:0]   wdata_i;
  logic [3:0]    be_i;
  logic          gnt_o, rvalid_o;
  logic [31:0]   rdata_o;
  logic [NB-1:0] ret_req_i, bank_on_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic        exp_rv = 1'b0;
  logic [31:0] exp_pop;

  always #5 clk_i = ~clk_i;

  sram_bank_array_pm #(
    .NumBanks     (4),
    .WordsPerBank (2048),
    .Interleaved  (1),
    .WakeupCycles (4),
    .IdleCycles   (64)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .be_i      (be_i),
    .gnt_o     (gnt_o),
    .rvalid_o  (rvalid_o),
    .rdata_o   (rdata_o),
    .ret_req_i (ret_req_i),
    .bank_on_o (bank_on_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: rvalid must follow each read grant by one cycle; data pops from the scoreboard.
  always @(negedge clk_i) begin
    check("rvalid_timing", 32'(rvalid_o), 32'(exp_rv));
    if (rvalid_o) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rdata_unexpected: got 0x%08h with no read outstanding", rdata_o);
      end else begin
        exp_pop = exp_q.pop_front();
        check("rdata", rdata_o, exp_pop);
      end
    end
    exp_rv = gnt_o & req_i & ~we_i & ~rst_i;
  end

  // Called at posedge+1; holds the request until granted, checks grant latency.
  task automatic access(input logic we, input logic [AW-1:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] exp_rd, input int exp_lat,
                        input string name);
    int lat = 0;
    bit got = 0;
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = addr;
    wdata_i = wd;
    be_i    = be;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk_i);
      if (gnt_o) got = 1;
      else lat++;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_gnt_timeout: no grant after %0d cycles, required %0d", name, lat, exp_lat);
    end else begin
      check({name, "_lat"}, lat, exp_lat);
      if (!we) exp_q.push_back(exp_rd);
    end
    @(posedge clk_i);
    #1;
    req_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0;
    wdata_i = '0; be_i = '0; ret_req_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_rvalid", 32'(rvalid_o), 32'h0);
    check("reset_rdata", rdata_o, 32'h0);
    check("reset_bank_on", 32'(bank_on_o), 32'hF);
    rst_i = 1'b0;

    // Idle timeout: no traffic, all banks drop together after 64 cycles.
    repeat (64) @(negedge clk_i);
    check("idle_63_still_on", 32'(bank_on_o), 32'hF);
    @(negedge clk_i);
    check("idle_64_all_ret", 32'(bank_on_o), 32'h0);

    @(posedge clk_i); #1; rst_i = 1'b1;
    @(posedge clk_i); #1; rst_i = 1'b0;
    check("reset_restores_on", 32'(bank_on_o), 32'hF);

    access(1'b1, 13'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, "wr_10");
    access(1'b0, 13'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0, "rd_10");

    for (int i = 0; i < 8; i++)
      access(1'b1, AW'(i), 32'hC0DE0000 | i, 4'hF, 32'h0, 0, $sformatf("wr_il%0d", i));
    check("il_wr_bank_on", 32'(bank_on_o), 32'hF);
    for (int i = 0; i < 8; i++)
      access(1'b0, AW'(i), 32'h0, 4'hF, 32'hC0DE0000 | i, 0, $sformatf("rd_il%0d", i));
    check("il_rd_bank_on", 32'(bank_on_o), 32'hF);

    access(1'b1, 13'h20, 32'hFFFFFFFF, 4'hF, 32'h0, 0, "wr_ff");
    access(1'b1, 13'h20, 32'h11223344, 4'b0101, 32'h0, 0, "wr_be");
    access(1'b0, 13'h20, 32'h0, 4'hF, 32'hFF22FF44, 0, "rd_be");

    // Pulsed retention on bank 2, then wake on access.
    ret_req_i = 4'b0100;
    @(posedge clk_i); #1; ret_req_i = 4'b0000;
    check("ret2_bank_on", 32'(bank_on_o), 32'hB);
    access(1'b0, 13'h2, 32'h0, 4'hF, 32'hC0DE0002, 5, "rd_wake2");
    check("wake2_bank_on", 32'(bank_on_o), 32'hF);

    // Retention held on bank 1 while a request is pending: grant waits for release plus wake.
    ret_req_i = 4'b0010;
    fork
      access(1'b0, 13'h1, 32'h0, 4'hF, 32'hC0DE0001, 8, "rd_held1");
      begin
        repeat (3) @(posedge clk_i);
        #1;
        ret_req_i = 4'b0000;
      end
    join

    // Reset while bank 3 wakes and a read is granted in the same cycle.
    ret_req_i = 4'b1000;
    @(posedge clk_i); #1; ret_req_i = 4'b0000;
    req_i = 1'b1; we_i = 1'b0; addr_i = 13'h3;
    @(posedge clk_i); #1;
    check("wake3_bank_on", 32'(bank_on_o), 32'h7);
    addr_i = 13'h10;
    rst_i  = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    req_i = 1'b0;
    check("rst_mid_rvalid", 32'(rvalid_o), 32'h0);
    check("rst_mid_rdata", rdata_o, 32'h0);
    check("rst_mid_bank_on", 32'(bank_on_o), 32'hF);

    access(1'b0, 13'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0, "rd_after_rst");
    access(1'b0, 13'h3, 32'h0, 4'hF, 32'hC0DE0003, 0, "rd3_after_rst");

    repeat (3) @(negedge clk_i);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
